// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ==========================================================================
// cpu_ctrl_fsm - fetch/decode sequencer driving ALU op and datapath strobes
// Revision 1.0
// ==========================================================================
module cpu_ctrl_fsm #(
  parameter int OPW = 4,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  data_in,
  output logic [OPW-1:0] op_out,
  output logic           im_int,
  output logic           rd,
  output logic           wr,
  output logic           load_ir,
  output logic           load_addr,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_acc,
  output logic           halt,
  output logic           illegal,
  output logic [7:0]     instr_cnt
);

  localparam logic [OPW-1:0] C_LDO    = OPW'(1);
  localparam logic [OPW-1:0] C_LDA    = OPW'(2);
  localparam logic [OPW-1:0] C_STO    = OPW'(3);
  localparam logic [OPW-1:0] C_PRE    = OPW'(4);
  localparam logic [OPW-1:0] C_ADD    = OPW'(5);
  localparam logic [OPW-1:0] C_ADN    = OPW'(7);
  localparam logic [OPW-1:0] C_INC    = OPW'(8);
  localparam logic [OPW-1:0] C_DEC    = OPW'(9);
  localparam logic [OPW-1:0] C_JMP    = OPW'(10);
  localparam logic [OPW-1:0] C_CLR    = OPW'(11);
  localparam logic [OPW-1:0] C_ILL_LO = OPW'(12);
  localparam logic [OPW-1:0] C_ILL_HI = OPW'(14);
  localparam logic [OPW-1:0] C_HLT    = OPW'(15);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_INCPC = 3'd1,
    S_ADDR  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] ir_q;
  logic [OPW-1:0] op_q;
  logic           illegal_q;
  logic [7:0]     cnt_q;
  logic           two_byte;
  logic           ir_illegal;
  logic           unused_lo;

  // Operand nibble belongs to the datapath IR, not to sequencing.
  assign unused_lo  = ^data_in[DW-OPW-1:0];
  assign two_byte   = (ir_q == C_LDO) || (ir_q == C_LDA) || (ir_q == C_STO) ||
                      (ir_q == C_PRE) || (ir_q == C_ADD) || (ir_q == C_JMP);
  assign ir_illegal = (ir_q >= C_ILL_LO) && (ir_q <= C_ILL_HI);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_INCPC;
      S_INCPC: state_d = two_byte ? S_ADDR : S_EXEC;
      S_ADDR:  state_d = S_EXEC;
      S_EXEC: begin
        if ((op_q == C_ADN) || (op_q == C_CLR)) state_d = S_WB;
        else if (op_q == C_HLT)                 state_d = S_HALT;
        else                                    state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: ir_q <= data_in[DW-1 -: OPW];
        S_INCPC: begin
          op_q <= ir_q;
          if (ir_illegal) illegal_q <= 1'b1;
        end
        S_EXEC, S_WB: begin
          if (state_d == S_FETCH) cnt_q <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from state alone; rst gating drops them mid-instruction.
  always_comb begin
    rd        = 1'b0;
    wr        = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    inc_pc    = 1'b0;
    load_pc   = 1'b0;
    load_acc  = 1'b0;
    im_int    = 1'b0;
    halt      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        S_INCPC: inc_pc = 1'b1;
        S_ADDR: begin
          rd = 1'b1;
          if (op_q == C_JMP) begin
            load_pc = 1'b1;
          end else begin
            load_addr = 1'b1;
            inc_pc    = 1'b1;
          end
        end
        S_EXEC: begin
          case (op_q)
            C_LDO, C_LDA, C_PRE, C_ADD, C_INC, C_DEC: load_acc = 1'b1;
            C_STO:                                    wr       = 1'b1;
            C_ADN, C_CLR:                             im_int   = 1'b1;
            default: ;
          endcase
        end
        S_WB:    load_acc = 1'b1;
        S_HALT:  halt     = 1'b1;
        default: ;
      endcase
    end
  end

  assign op_out    = op_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ==========================================================================
// tb_cpu_ctrl_fsm - randomized self-checking bench against a cycle-table model
// Revision 1.0
// ==========================================================================
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic [3:0] op_out;
  logic       im_int, rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, halt, illegal;
  logic [7:0] instr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [3:0] m_op;
  int         m_cnt;
  logic       m_ill;

  logic [12:0] obs [1:6];

  cpu_ctrl_fsm #(.OPW(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .op_out(op_out), .im_int(im_int),
    .rd(rd), .wr(wr), .load_ir(load_ir), .load_addr(load_addr), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_acc(load_acc), .halt(halt), .illegal(illegal),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic is_two(input logic [3:0] o);
    return (o == 4'h1) || (o == 4'h2) || (o == 4'h3) || (o == 4'h4) ||
           (o == 4'h5) || (o == 4'hA);
  endfunction

  function automatic int exp_len(input logic [3:0] o);
    return (is_two(o) || o == 4'h7 || o == 4'hB) ? 4 : 3;
  endfunction

  // {rd,wr,load_ir,load_addr,inc_pc,load_pc,load_acc,im_int,halt} for cycle c of opcode o
  function automatic logic [8:0] exp_vec(input logic [3:0] o, input int c);
    logic r_, w_, ir_, la_, ip_, lp_, acc_, im_;
    int ex;
    {r_, w_, ir_, la_, ip_, lp_, acc_, im_} = 8'd0;
    ex = is_two(o) ? 4 : 3;
    if (c == 1) begin
      r_ = 1'b1; ir_ = 1'b1;
    end else if (c == 2) begin
      ip_ = 1'b1;
    end else if (c == 3 && is_two(o)) begin
      r_ = 1'b1;
      if (o == 4'hA) lp_ = 1'b1;
      else begin la_ = 1'b1; ip_ = 1'b1; end
    end else if (c == ex) begin
      if (o == 4'h1 || o == 4'h2 || o == 4'h4 || o == 4'h5 || o == 4'h8 || o == 4'h9) acc_ = 1'b1;
      else if (o == 4'h3) w_ = 1'b1;
      else if (o == 4'h7 || o == 4'hB) im_ = 1'b1;
    end else if (c == ex + 1 && (o == 4'h7 || o == 4'hB)) begin
      acc_ = 1'b1;
    end
    return {r_, w_, ir_, la_, ip_, lp_, acc_, im_, 1'b0};
  endfunction

  task automatic retire(input logic [3:0] o);
    m_op = o;
    if (o >= 4'hC && o <= 4'hE) m_ill = 1'b1;
    if (o != 4'hF) m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_in = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_op = 4'h0; m_cnt = 0; m_ill = 1'b0;
  endtask

  // Drives one instruction starting just after an edge, recording outputs per cycle.
  task automatic drive_instr(input logic [7:0] opb, input logic [7:0] ab, input int n);
    for (int c = 1; c <= n; c++) begin
      if (c == 1) data_in = opb;
      else if (c == 3 && is_two(opb[7:4])) data_in = ab;
      else data_in = 8'($urandom);
      @(negedge clk);
      obs[c] = {rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt, op_out};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt} !== 9'd0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0", {rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt});
    end
    n_chk++;
    if (op_out !== 4'h0) begin n_fail++; $display("FAIL reset_op: got %h want 0", op_out); end
    n_chk++;
    if (instr_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", instr_cnt); end
    n_chk++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    @(posedge clk);
    #1 rst = 1'b0;
    m_op = 4'h0; m_cnt = 0; m_ill = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rd !== 1'b1) begin n_fail++; $display("FAIL reset_first_rd: got %b want 1", rd); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_prog(input string name, input logic [7:0] p [4], input int np);
    logic [3:0]  o;
    logic [12:0] e;
    do_reset();
    for (int k = 0; k < np; k++) begin
      o = p[k][7:4];
      drive_instr(p[k], p[k+1 < 4 ? k+1 : k], exp_len(o));
      for (int c = 1; c <= exp_len(o); c++) begin
        e = {exp_vec(o, c), (c <= 2) ? m_op : o};
        n_chk++;
        if (obs[c] !== e) begin
          n_fail++; $display("FAIL %s instr%0d cyc%0d: got %h want %h", name, k, c, obs[c], e);
        end
      end
      retire(o);
      if (is_two(o)) k++;
      n_chk++;
      if (instr_cnt !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL %s_cnt: got %0d want %0d", name, instr_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_illegal_halt();
    logic [3:0]  o;
    logic [12:0] e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? 4'hC : 4'hF;
      drive_instr({o, 4'h0}, 8'h00, 3);
      for (int c = 1; c <= 3; c++) begin
        e = {exp_vec(o, c), (c <= 2) ? m_op : o};
        n_chk++;
        if (obs[c] !== e) begin
          n_fail++; $display("FAIL illhlt instr%0d cyc%0d: got %h want %h", k, c, obs[c], e);
        end
      end
      retire(o);
      n_chk++;
      if (illegal !== m_ill) begin n_fail++; $display("FAIL illegal_flag: got %b want %b", illegal, m_ill); end
    end
    for (int t = 0; t < 20; t++) begin
      data_in = 8'($urandom);
      @(negedge clk);
      n_chk++;
      if ({rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt, op_out} !== {9'b000000001, 4'hF}) begin
        n_fail++; $display("FAIL halt_hold t%0d: got %h want %h", t,
          {rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt, op_out}, {9'b000000001, 4'hF});
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (instr_cnt !== 8'd1) begin n_fail++; $display("FAIL halt_cnt: got %0d want 1", instr_cnt); end
  endtask

  task automatic test_rst_mid_sto();
    logic [12:0] e;
    do_reset();
    drive_instr(8'h30, 8'h44, 3);
    for (int c = 1; c <= 3; c++) begin
      e = {exp_vec(4'h3, c), (c <= 2) ? m_op : 4'h3};
      n_chk++;
      if (obs[c] !== e) begin n_fail++; $display("FAIL sto cyc%0d: got %h want %h", c, obs[c], e); end
    end
    data_in = 8'($urandom);
    @(negedge clk);
    n_chk++;
    if (wr !== 1'b1) begin n_fail++; $display("FAIL sto_exec_wr: got %b want 1", wr); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt} !== 9'd0) begin
      n_fail++; $display("FAIL rst_async_strobes: got %b want 0", {rd, wr, load_ir, load_addr, inc_pc, load_pc, load_acc, im_int, halt});
    end
    n_chk++;
    if (op_out !== 4'h0 || instr_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_async_regs: got op %h cnt %0d want op 0 cnt 0", op_out, instr_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_op = 4'h0; m_cnt = 0; m_ill = 1'b0;
    drive_instr(8'h81, 8'h00, 3);
    for (int c = 1; c <= 3; c++) begin
      e = {exp_vec(4'h8, c), (c <= 2) ? m_op : 4'h8};
      n_chk++;
      if (obs[c] !== e) begin n_fail++; $display("FAIL restart cyc%0d: got %h want %h", c, obs[c], e); end
    end
    retire(4'h8);
    n_chk++;
    if (instr_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL restart_cnt: got %0d want %0d", instr_cnt, m_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 256; k++) begin
      drive_instr(8'h00, 8'h00, 3);
      retire(4'h0);
      if (k == 254 || k == 255) begin
        n_chk++;
        if (instr_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL wrap k%0d: got %0d want %0d", k, instr_cnt, m_cnt); end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [12:0] e;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      o = 4'($urandom_range(0, 14));
      drive_instr({o, 4'($urandom)}, 8'($urandom), exp_len(o));
      for (int c = 1; c <= exp_len(o); c++) begin
        e = {exp_vec(o, c), (c <= 2) ? m_op : o};
        n_chk++;
        if (obs[c] !== e) begin
          n_fail++; $display("FAIL random instr%0d op%h cyc%0d: got %h want %h", k, o, c, obs[c], e);
        end
      end
      retire(o);
      n_chk++;
      if (instr_cnt !== 8'(m_cnt) || illegal !== m_ill) begin
        n_fail++; $display("FAIL random_state instr%0d: got cnt %0d ill %b want cnt %0d ill %b",
                           k, instr_cnt, illegal, m_cnt, m_ill);
      end
    end
  endtask

  initial begin
    logic [7:0] p [4];
    test_reset();
    p = '{8'h81, 8'h00, 8'h00, 8'h00}; test_prog("inc", p, 1);
    p = '{8'h10, 8'h2A, 8'h00, 8'h00}; test_prog("ldo", p, 2);
    p = '{8'h73, 8'hB0, 8'h00, 8'h00}; test_prog("adn_clr", p, 2);
    p = '{8'hA0, 8'h05, 8'h00, 8'h00}; test_prog("jmp", p, 3);
    test_illegal_halt();
    test_rst_mid_sto();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Instruction sequencer for the 8-bit CPU. It fetches instruction bytes from program memory, decodes the 4-bit opcode, and drives the ALU `op` and `im_int` inputs. It also produces the PC, accumulator, IR, address-register and memory strobes that move data around the ALU. It sits between the memory data bus and the datapath and is the only block that changes ALU state.

## Interface
- `OPW`, 4: opcode width (upper nibble of instruction byte).
- `DW`, 8: data/instruction byte width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DW  memory read data (instruction or operand byte).
- `op_out`  out  OPW  opcode to ALU `op`.
- `im_int`  out  1  one-cycle pulse to ALU temp-register capture.
- `rd`  out  1  memory read strobe.
- `wr`  out  1  memory write strobe (accumulator to RAM).
- `load_ir`  out  1  capture `data_in` into IR.
- `load_addr`  out  1  capture `data_in` into address register.
- `inc_pc`  out  1  PC <= PC+1.
- `load_pc`  out  1  PC <= address register / `data_in` (JMP).
- `load_acc`  out  1  accumulator <= ALU result.
- `halt`  out  1  high while in HALT.
- `illegal`  out  1  sticky; set on opcode 1100–1110.
- `instr_cnt`  out  8  retired-instruction count.

## Operation
- Opcodes: NOP 0000, LDO 0001, LDA 0010, STO 0011, PRE 0100, ADD 0101, LDM 0110, ADN 0111, INC 1000, DEC 1001, JMP 1010, CLR 1011, HLT 1111.
- Two-byte instructions (opcode byte + address byte): LDO, LDA, STO, PRE, ADD, JMP. All others are one byte. The low nibble of an ADN byte is its immediate.
- States: FETCH, INCPC, ADDR, EXEC, WB, HALT. Encoding is free. Reset state is FETCH.
- FETCH: `rd`=1, `load_ir`=1. Next state is INCPC.
- INCPC: `inc_pc`=1. `op_out` is registered from IR[7:4] at the end of this cycle. Next state is ADDR for a two-byte opcode, otherwise EXEC.
- ADDR: `rd`=1. For JMP, `load_pc`=1 and `inc_pc`=0. For the others, `load_addr`=1 and `inc_pc`=1. Next state is EXEC.
- EXEC:
  - LDO/LDA/PRE/ADD/INC/DEC: `load_acc`=1. Next state is FETCH.
  - STO: `wr`=1. Next state is FETCH.
  - NOP/LDM/JMP/illegal: no strobes. Next state is FETCH.
  - ADN/CLR: `im_int`=1. Next state is WB.
  - HLT: next state is HALT.
- WB (ADN/CLR only): `load_acc`=1, capturing the ALU temp register. Next state is FETCH.
- HALT: `halt`=1, all strobes 0, `op_out` held at 1111. Only `rst` exits HALT.
- Illegal opcodes (1100–1110) set `illegal` and execute as NOP. `illegal` clears only on `rst`.
- `instr_cnt` increments by 1 on every transition into FETCH from EXEC or WB, and wraps 255 -> 0. HLT is not counted.
- At most one of `rd`/`wr` is high in any cycle. `load_pc` and `inc_pc` are never high together.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from `data_in` to any output.
- Reset values: state FETCH, `op_out`=0000, `illegal`=0, `instr_cnt`=0. All strobes and `halt` are 0 while `rst` is high. The first `rd` appears in the first cycle after `rst` deasserts.
- Instruction latency in clocks:
  - One-byte instructions, except ADN/CLR: 3.
  - Two-byte instructions: 4.
  - ADN/CLR: 4.
  - HLT: 3 cycles to reach HALT.
- `im_int` is high for exactly one cycle (EXEC). Its rising edge precedes WB `load_acc` by one cycle, so the ALU temp register is stable before capture.
- `op_out` changes only at the INCPC->next edge and is stable through EXEC/WB.
- If `rst` asserts mid-instruction (any state), all strobes drop to 0 immediately. No partial `wr` or `load_acc` completes.

## Test plan
- Reset, then program {0x81 INC}: FETCH/INCPC/EXEC in 3 clocks, `load_acc` high only in cycle 3, `op_out`=1000, `instr_cnt`=1.
- Program {0x10, 0x2A} (LDO addr 0x2A): `rd` in cycles 1 and 3, `load_addr` in cycle 3, `inc_pc` in cycles 2 and 3, `load_acc` in cycle 4.
- Program {0x73 ADN #3}: `im_int` single pulse in cycle 3, `load_acc` in cycle 4, 4 cycles total. Follow with 0xB0 CLR: same `im_int`/`load_acc` pattern, `op_out`=1011.
- Program {0xA0, 0x05} (JMP 0x05): `load_pc`=1 with `inc_pc`=0 in cycle 3, no `load_acc`. Next FETCH occurs in cycle 5.
- Program {0xC0, 0xF0}: `illegal` set after the first instruction and executed as a 3-cycle NOP. HLT then gives `halt`=1 from cycle 7 onward with no strobes for 20 clocks, and `instr_cnt`=1.
- Assert `rst` during EXEC of STO: `wr` drops to 0 asynchronously. After release, `op_out`=0000, `instr_cnt`=0, fetch restarts. Separately, run 256 NOPs and check that `instr_cnt` wraps to 0.
